// File: rtl/te_egress_packer.sv
// Trace egress packer: folds retired uops into instruction blocks and
// queues closed blocks in a small output FIFO for the trace encoder.
// Optional feature: define TE_EGRESS_TIMEOUT_EN to force-close a block
// that has been left open for TIMEOUT_CYC idle cycles.

package mure_pkg;
    typedef enum logic [3:0] {
        ItypeStd  = 4'd0,
        ItypeExc  = 4'd1,
        ItypeInt  = 4'd2,
        ItypeEret = 4'd3,
        ItypeNtb  = 4'd4,
        ItypeTb   = 4'd5,
        ItypeUj   = 4'd6
    } itype_e;

    typedef struct packed {
        itype_e      itype;
        logic [63:0] pc;
        logic        compressed;
    } uop_entry_s;
endpackage

module te_egress_packer #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned IRETIRE_W   = 8,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  mure_pkg::uop_entry_s   uop_i,
    output logic                   ready_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output mure_pkg::itype_e       itype_o,
    output logic [XLEN-1:0]        iaddr_o,
    output logic [IRETIRE_W-1:0]   iretire_o,
    output logic                   ilastsize_o
);
    import mure_pkg::*;

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        itype_e               itype;
        logic [XLEN-1:0]      iaddr;
        logic [IRETIRE_W-1:0] iretire;
        logic                 ilastsize;
    } blk_s;

    typedef enum logic [1:0] {StIdle, StAccum, StExcPend} state_e;

    state_e               state_q, state_d;
    logic [XLEN-1:0]      blk_addr_q, blk_addr_d;
    logic [IRETIRE_W-1:0] blk_cnt_q, blk_cnt_d;
    logic                 blk_last_q, blk_last_d;
    blk_s                 exc_q, exc_d;
    logic                 init_q;

    blk_s                 mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;

    logic                 full, accept, pop, push, is_std, is_exc;
    blk_s                 push_blk, head;
    logic [IRETIRE_W:0]   size, sum;

`ifdef TE_EGRESS_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0]      tmo_q, tmo_d;
`endif

    assign full    = (count_q == CntW'(FIFO_DEPTH));
    // ready stays low until the first clock after reset release
    assign ready_o = init_q && !full && (state_q != StExcPend);
    assign accept  = valid_i && ready_o;
    assign valid_o = (count_q != '0);
    assign pop     = valid_o && ready_i;

    assign is_std  = (uop_i.itype == ItypeStd);
    assign is_exc  = (uop_i.itype == ItypeExc) || (uop_i.itype == ItypeInt);
    assign size    = uop_i.compressed ? (IRETIRE_W+1)'(1) : (IRETIRE_W+1)'(2);
    assign sum     = {1'b0, blk_cnt_q} + size;

    // Head outputs are forced to zero whenever the FIFO is empty
    assign head        = mem_q[rd_ptr_q];
    assign itype_o     = valid_o ? head.itype : ItypeStd;
    assign iaddr_o     = valid_o ? head.iaddr : '0;
    assign iretire_o   = valid_o ? head.iretire : '0;
    assign ilastsize_o = valid_o ? head.ilastsize : 1'b0;

    // Block-building FSM: next state, open-block update and single FIFO push
    always_comb begin
        state_d    = state_q;
        blk_addr_d = blk_addr_q;
        blk_cnt_d  = blk_cnt_q;
        blk_last_d = blk_last_q;
        exc_d      = exc_q;
        push       = 1'b0;
        push_blk   = '0;
`ifdef TE_EGRESS_TIMEOUT_EN
        tmo_d = '0;
        if (state_q == StAccum && !accept) begin
            tmo_d = (tmo_q == TmoW'(TIMEOUT_CYC)) ? tmo_q : tmo_q + 1'b1;
        end
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_std) begin
                        blk_addr_d = uop_i.pc[XLEN-1:0];
                        blk_cnt_d  = size[IRETIRE_W-1:0];
                        blk_last_d = !uop_i.compressed;
                        state_d    = StAccum;
                    end else if (is_exc) begin
                        push     = 1'b1;
                        push_blk = '{uop_i.itype, uop_i.pc[XLEN-1:0], '0, 1'b0};
                    end else begin
                        push     = 1'b1;
                        push_blk = '{uop_i.itype, uop_i.pc[XLEN-1:0],
                                     size[IRETIRE_W-1:0], !uop_i.compressed};
                    end
                end
            end
            StAccum: begin
                if (accept) begin
                    if (is_std) begin
                        if (sum[IRETIRE_W]) begin
                            // Retire count would overflow: close and restart
                            push       = 1'b1;
                            push_blk   = '{ItypeStd, blk_addr_q, blk_cnt_q, blk_last_q};
                            blk_addr_d = uop_i.pc[XLEN-1:0];
                            blk_cnt_d  = size[IRETIRE_W-1:0];
                        end else begin
                            blk_cnt_d = sum[IRETIRE_W-1:0];
                        end
                        blk_last_d = !uop_i.compressed;
                    end else if (is_exc) begin
                        push     = 1'b1;
                        push_blk = '{ItypeStd, blk_addr_q, blk_cnt_q, blk_last_q};
                        exc_d    = '{uop_i.itype, uop_i.pc[XLEN-1:0], '0, 1'b0};
                        state_d  = StExcPend;
                    end else begin
                        push     = 1'b1;
                        push_blk = '{uop_i.itype, blk_addr_q, sum[IRETIRE_W-1:0],
                                     !uop_i.compressed};
                        state_d  = StIdle;
                    end
                end
`ifdef TE_EGRESS_TIMEOUT_EN
                else if (tmo_q == TmoW'(TIMEOUT_CYC) && !full) begin
                    push     = 1'b1;
                    push_blk = '{ItypeStd, blk_addr_q, blk_cnt_q, blk_last_q};
                    state_d  = StIdle;
                end
`endif
            end
            StExcPend: begin
                if (!full) begin
                    push    = 1'b1;
                    push_blk = exc_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, open-block and FIFO pointer state with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            blk_addr_q <= '0;
            blk_cnt_q  <= '0;
            blk_last_q <= 1'b0;
            exc_q      <= '0;
            init_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef TE_EGRESS_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            blk_addr_q <= blk_addr_d;
            blk_cnt_q  <= blk_cnt_d;
            blk_last_q <= blk_last_d;
            exc_q      <= exc_d;
            init_q     <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_q + CntW'(push) - CntW'(pop);
`ifdef TE_EGRESS_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    // FIFO storage needs no reset; head outputs are masked by valid_o
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_blk;
    end

endmodule

// File: tb/tb_te_egress_packer.sv
// Directed self-checking bench for te_egress_packer (IRETIRE_W=4, FIFO_DEPTH=4).
module tb_te_egress_packer;
    import mure_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    uop_entry_s  uop_i;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;
    itype_e      itype_o;
    logic [63:0] iaddr_o;
    logic [3:0]  iretire_o;
    logic        ilastsize_o;

    int n_checks = 0;
    int n_fail   = 0;

    te_egress_packer #(
        .XLEN        (64),
        .FIFO_DEPTH  (4),
        .IRETIRE_W   (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid_i),
        .uop_i       (uop_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .itype_o     (itype_o),
        .iaddr_o     (iaddr_o),
        .iretire_o   (iretire_o),
        .ilastsize_o (ilastsize_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input itype_e t, input logic [63:0] pc, input logic c);
        int w = 0;
        valid_i = 1'b1;
        uop_i   = '{itype: t, pc: pc, compressed: c};
        while (!ready_o && w < 50) begin
            tick();
            w++;
        end
        if (!ready_o) check("send_wait_timeout", 64'd0, 64'd1);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic expect_head(input string tag, input itype_e t, input logic [63:0] a,
                               input logic [3:0] r, input logic l);
        check({tag, "_valid"}, {63'd0, valid_o}, 64'd1);
        check({tag, "_itype"}, {60'd0, itype_o}, {60'd0, t});
        check({tag, "_iaddr"}, iaddr_o, a);
        check({tag, "_iretire"}, {60'd0, iretire_o}, {60'd0, r});
        check({tag, "_ilastsize"}, {63'd0, ilastsize_o}, {63'd0, l});
    endtask

    task automatic pop_one();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    initial begin
        int got;
        int cyc;
        logic acc;
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        uop_i   = '0;
        repeat (3) tick();
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_iaddr", iaddr_o, 64'd0);
        check("rst_iretire", {60'd0, iretire_o}, 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {63'd0, ready_o}, 64'd1);

        // Three 32-bit STD uops closed by a compressed taken branch
        send(ItypeStd, 64'h1000, 1'b0);
        send(ItypeStd, 64'h1004, 1'b0);
        send(ItypeStd, 64'h1008, 1'b0);
        send(ItypeTb,  64'h100C, 1'b1);
        expect_head("blk_branch", ItypeTb, 64'h1000, 4'd7, 1'b0);
        pop_one();
        check("blk_branch_drained", {63'd0, valid_o}, 64'd0);

        // Exception inside an open block: ready drops for exactly one cycle
        send(ItypeStd, 64'h1800, 1'b0);
        send(ItypeStd, 64'h1804, 1'b0);
        send(ItypeExc, 64'h2000, 1'b0);
        check("exc_pend_ready", {63'd0, ready_o}, 64'd0);
        expect_head("exc_blk", ItypeStd, 64'h1800, 4'd4, 1'b1);
        tick();
        check("exc_ready_back", {63'd0, ready_o}, 64'd1);
        pop_one();
        expect_head("exc_entry", ItypeExc, 64'h2000, 4'd0, 1'b0);
        pop_one();
        check("exc_drained", {63'd0, valid_o}, 64'd0);

        // Retire-count overflow: 8 uops of size 2 with a 4-bit counter
        for (int i = 0; i < 8; i++) send(ItypeStd, 64'h3000 + 64'(4 * i), 1'b0);
        expect_head("ovf_first", ItypeStd, 64'h3000, 4'd14, 1'b1);
        send(ItypeTb, 64'h3020, 1'b1);
        pop_one();
        expect_head("ovf_second", ItypeTb, 64'h301C, 4'd3, 1'b0);
        pop_one();

        // Interrupt from idle: zero-retire entry, no stall
        send(ItypeInt, 64'h5000, 1'b0);
        check("int_ready", {63'd0, ready_o}, 64'd1);
        expect_head("int_entry", ItypeInt, 64'h5000, 4'd0, 1'b0);
        pop_one();

        // Back-pressure: four closing uops fill the FIFO, the fifth waits
        for (int i = 0; i < 4; i++) send(ItypeUj, 64'h4000 + 64'(4 * i), 1'b0);
        check("full_ready", {63'd0, ready_o}, 64'd0);
        valid_i = 1'b1;
        uop_i   = '{itype: ItypeUj, pc: 64'h4010, compressed: 1'b0};
        tick();
        check("full_held_ready", {63'd0, ready_o}, 64'd0);
        check("full_held_valid", {63'd0, valid_o}, 64'd1);
        ready_i = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            acc = valid_i && ready_o;
            if (valid_o) begin
                check("bp_iaddr", iaddr_o, 64'h4000 + 64'(4 * got));
                check("bp_iretire", {60'd0, iretire_o}, 64'd2);
                got++;
            end
            tick();
            if (acc) valid_i = 1'b0;
        end
        ready_i = 1'b0;
        check("bp_delivered", 64'(got), 64'd5);
        check("bp_drained", {63'd0, valid_o}, 64'd0);

        // Reset while a block is open and two entries are queued
        send(ItypeUj, 64'h6100, 1'b0);
        send(ItypeUj, 64'h6104, 1'b0);
        send(ItypeStd, 64'h6108, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", {63'd0, valid_o}, 64'd0);
        check("midrst_ready", {63'd0, ready_o}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("postrst_valid", {63'd0, valid_o}, 64'd0);
        send(ItypeTb, 64'h6000, 1'b1);
        expect_head("postrst_blk", ItypeTb, 64'h6000, 4'd1, 1'b0);
        pop_one();

        // Open block left idle
        send(ItypeStd, 64'h7000, 1'b0);
        cyc = 0;
        while (!valid_o && cyc < 40) begin
            tick();
            cyc++;
        end
`ifdef TE_EGRESS_TIMEOUT_EN
        expect_head("tmo_blk", ItypeStd, 64'h7000, 4'd2, 1'b1);
        check("tmo_not_early", {63'd0, (cyc >= 15)}, 64'd1);
`else
        check("no_tmo_valid", {63'd0, valid_o}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
